// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered RV32I ALU with valid/ready handshake
// Optional iterative RV32M multiply/divide unit compiled in when ALU_SEQ_MDIV_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] pc_plus_4,
    output logic [WIDTH-1:0] jump_target,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

`ifdef ALU_SEQ_MDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, pc4_q, pc4_d, tgt_q, tgt_d;
    logic             zero_q, zero_d, taken_q, taken_d, ill_q, ill_d, res_we;

    logic [WIDTH-1:0] sum, diff, shl, shr, sra_v, pc4, base_res, tgt;
    logic [SW-1:0]    shamt;
    logic             lt_s, lt_u, taken, base_ill;

    assign shamt = rs2[SW-1:0];
    assign sum   = rs1 + rs2;
    assign diff  = rs1 - rs2;
    assign shl   = rs1 << shamt;
    assign shr   = rs1 >> shamt;
    assign sra_v = $signed(rs1) >>> shamt;
    assign lt_s  = $signed(rs1) < $signed(rs2);
    assign lt_u  = rs1 < rs2;
    assign pc4   = pc + WIDTH'(4);

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        taken    = 1'b0;
        tgt      = pc + rs2;
        case (opcode)
            OP_R, OP_I: begin
                case (func3)
                    3'b000:  base_res = (opcode == OP_R && func7[5]) ? diff : sum;
                    3'b001:  base_res = shl;
                    3'b010:  base_res = {{(WIDTH-1){1'b0}}, lt_s};
                    3'b011:  base_res = {{(WIDTH-1){1'b0}}, lt_u};
                    3'b100:  base_res = rs1 ^ rs2;
                    3'b101:  base_res = func7[5] ? sra_v : shr;
                    3'b110:  base_res = rs1 | rs2;
                    default: base_res = rs1 & rs2;
                endcase
                // Only R-type carries a real func7; for OP-IMM it is immediate bits.
                if (opcode == OP_R && !(func7 == 7'b0000000 ||
                    (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101)))) begin
                    base_ill = 1'b1;
                    base_res = '0;
                end
            end
            OP_LD, OP_ST: base_res = sum;
            OP_BR: begin
                base_res = diff;
                case (func3)
                    3'b000:  taken = (rs1 == rs2);
                    3'b001:  taken = (rs1 != rs2);
                    3'b100:  taken = lt_s;
                    3'b101:  taken = !lt_s;
                    3'b110:  taken = lt_u;
                    3'b111:  taken = !lt_u;
                    default: begin
                        base_ill = 1'b1;
                        base_res = '0;
                    end
                endcase
            end
            OP_JALR: begin
                base_res = pc4;
                tgt      = {sum[WIDTH-1:1], 1'b0};
            end
            OP_LUI:  base_res = rs2;
            default: base_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MDIV_EN
    logic [2:0]         f3_q, f3_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, addend, prod;
    logic [WIDTH-1:0]   mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   quo_n, rem_n, mag1, mag2;
    logic [WIDTH:0]     rsh, rsub;
    logic               bsgn_q, bsgn_d, negq_q, negq_d, negr_q, negr_d;
    logic               is_m, last, sgn, s1, s2, asgn, ovf;

    assign is_m   = (opcode == OP_R) && (func7 == 7'b0000001);
    assign last   = (cnt_q == SW'(WIDTH-1));
    // Signed multiplier: the top bit weighs -2^(WIDTH-1), so the last step subtracts.
    assign addend = mplier_q[0] ? mcand_q : '0;
    assign prod   = (last && bsgn_q) ? acc_q - addend : acc_q + addend;
    assign rsh    = {rem_q, quo_q[WIDTH-1]};
    assign rsub   = rsh - {1'b0, dvsr_q};
    assign quo_n  = {quo_q[WIDTH-2:0], ~rsub[WIDTH]};
    assign rem_n  = rsub[WIDTH] ? rsh[WIDTH-1:0] : rsub[WIDTH-1:0];
    assign sgn    = ~func3[0];
    assign s1     = sgn & rs1[WIDTH-1];
    assign s2     = sgn & rs2[WIDTH-1];
    assign mag1   = s1 ? -rs1 : rs1;
    assign mag2   = s2 ? -rs2 : rs2;
    assign asgn   = func3[1] ^ func3[0];
    assign ovf    = sgn && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
    assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        pc4_d   = pc4_q;
        tgt_d   = tgt_q;
        taken_d = taken_q;
        ill_d   = ill_q;
        res_we  = 1'b0;
`ifdef ALU_SEQ_MDIV_EN
        f3_d     = f3_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        bsgn_d   = bsgn_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
`endif
        case (state_q)
            S_IDLE: if (in_valid) begin
                pc4_d   = pc4;
                tgt_d   = tgt;
                taken_d = taken;
                ill_d   = base_ill;
                res_d   = base_res;
                res_we  = 1'b1;
                state_d = S_DONE;
`ifdef ALU_SEQ_MDIV_EN
                if (is_m) begin
                    ill_d  = 1'b0;
                    f3_d   = func3;
                    cnt_d  = '0;
                    res_d  = res_q;
                    res_we = 1'b0;
                    if (!func3[2]) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{asgn & rs1[WIDTH-1]}}, rs1};
                        mplier_d = rs2;
                        bsgn_d   = (func3[1:0] == 2'b01);
                        state_d  = S_MUL;
                    end else if (rs2 == '0) begin
                        res_d  = func3[1] ? rs1 : '1;
                        res_we = 1'b1;
                    end else if (ovf) begin
                        res_d  = func3[1] ? '0 : rs1;
                        res_we = 1'b1;
                    end else begin
                        rem_d   = '0;
                        quo_d   = mag1;
                        dvsr_d  = mag2;
                        negq_d  = s1 ^ s2;
                        negr_d  = s1;
                        state_d = S_DIV;
                    end
                end
`endif
            end
`ifdef ALU_SEQ_MDIV_EN
            S_MUL: begin
                acc_d    = prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (last) begin
                    res_d   = (f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                    res_we  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + SW'(1);
                if (last) begin
                    res_d   = f3_q[1] ? (negr_q ? -rem_n : rem_n) : (negq_q ? -quo_n : quo_n);
                    res_we  = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        zero_d = res_we ? (res_d == '0) : zero_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            pc4_q   <= '0;
            tgt_q   <= '0;
            zero_q  <= 1'b0;
            taken_q <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_SEQ_MDIV_EN
            f3_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bsgn_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            pc4_q   <= pc4_d;
            tgt_q   <= tgt_d;
            zero_q  <= zero_d;
            taken_q <= taken_d;
            ill_q   <= ill_d;
`ifdef ALU_SEQ_MDIV_EN
            f3_q     <= f3_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            bsgn_q   <= bsgn_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
`endif
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign alu_result   = res_q;
    assign pc_plus_4    = pc4_q;
    assign jump_target  = tgt_q;
    assign zero         = zero_q;
    assign branch_taken = taken_q;
    assign illegal      = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq; expectations follow ALU_SEQ_MDIV_EN
module tb_alu_seq;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] F7_M    = 7'b0000001;
`ifdef ALU_SEQ_MDIV_EN
    localparam bit MDIV = 1'b1;
`else
    localparam bit MDIV = 1'b0;
`endif
    localparam int LM = MDIV ? 33 : 1;

    logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, pc, alu_result, pc_plus_4, jump_target;
    logic        zero, branch_taken, illegal, busy;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .pc_plus_4(pc_plus_4), .jump_target(jump_target), .zero(zero),
        .branch_taken(branch_taken), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        bit          cres;
        logic [31:0] pc4;
        logic [31:0] tgt;
        bit          ctgt;
        bit          taken;
        bit          ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errs = 0, checks = 0, cyc = 0, busy_total = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (busy) busy_total++;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected result: got out_valid=1 alu_result=0x%h expected no result", alu_result);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " latency"}, cyc - e.acc, e.lat);
                    if (e.cres) begin
                        chk({e.name, " result"}, alu_result, e.res);
                        chk({e.name, " zero"}, zero, e.res == 0);
                    end
                    chk({e.name, " pc_plus_4"}, pc_plus_4, e.pc4);
                    chk({e.name, " branch_taken"}, branch_taken, e.taken);
                    chk({e.name, " illegal"}, illegal, e.ill);
                    if (e.ctgt) chk({e.name, " jump_target"}, jump_target, e.tgt);
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] eres, input bit cres,
                         input logic [31:0] etgt, input bit ctgt, input bit etk, input bit eill,
                         input int lat, input bit push);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " in_ready before accept"}, in_ready, 1'b1);
        opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; pc = p;
        in_valid = 1'b1;
        e.name = nm; e.res = eres; e.cres = cres; e.pc4 = p + 32'd4; e.tgt = etgt;
        e.ctgt = ctgt; e.taken = etk; e.ill = eill; e.lat = lat; e.acc = cyc;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
        rs1 = $urandom; rs2 = $urandom; pc = $urandom;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " pending results"}, sb.size(), 0);
    endtask

    initial begin
        int b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func3 = '0; func7 = '0; rs1 = '0; rs2 = '0; pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset alu_result", alu_result, 32'h0);
        chk("reset pc_plus_4", pc_plus_4, 32'h0);
        chk("reset jump_target", jump_target, 32'h0);
        chk("reset zero", zero, 1'b0);
        chk("reset branch_taken", branch_taken, 1'b0);
        chk("reset illegal", illegal, 1'b0);
        chk("reset busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue("add", OP_R, 3'b000, 7'h00, 32'd5, 32'd3, 32'h100, 32'h8, 1, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("add in_ready while done", in_ready, 1'b0);
        @(negedge clk);
        chk("add in_ready after handshake", in_ready, 1'b1);

        issue("sub", OP_R, 3'b000, 7'h20, 32'd5, 32'd8, 32'h104, 32'hFFFFFFFD, 1, 0, 0, 0, 0, 1, 1);
        issue("add_wrap", OP_R, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h108, 32'h0, 1, 0, 0, 0, 0, 1, 1);
        issue("srai", OP_I, 3'b101, 7'h20, 32'h80000000, 32'h404, 32'h10C, 32'hF8000000, 1, 0, 0, 0, 0, 1, 1);
        issue("srl", OP_R, 3'b101, 7'h00, 32'h80000000, 32'h24, 32'h110, 32'h08000000, 1, 0, 0, 0, 0, 1, 1);
        issue("slt", OP_R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h114, 32'h1, 1, 0, 0, 0, 0, 1, 1);
        issue("sltu", OP_R, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h118, 32'h0, 1, 0, 0, 0, 0, 1, 1);
        issue("lui", OP_LUI, 3'b000, 7'h00, 32'h0, 32'h12345000, 32'h11C, 32'h12345000, 1, 0, 0, 0, 0, 1, 1);
        issue("jalr", OP_JALR, 3'b000, 7'h00, 32'h1001, 32'h10, 32'h200, 32'h204, 1, 32'h1010, 1, 0, 0, 1, 1);
        issue("blt", OP_BR, 3'b100, 7'h00, 32'hFFFFFFFE, 32'd1, 32'h300, 0, 0, 32'h301, 1, 1, 0, 1, 1);
        issue("bgeu", OP_BR, 3'b111, 7'h00, 32'd1, 32'hFFFFFFFF, 32'h300, 0, 0, 32'h2FF, 1, 0, 0, 1, 1);
        issue("sw", OP_ST, 3'b010, 7'h00, 32'h1000, 32'hFFFFFFFC, 32'h120, 32'hFFC, 1, 0, 0, 0, 0, 1, 1);
        issue("badop", 7'h7F, 3'b000, 7'h00, 32'd1, 32'd2, 32'h124, 32'h0, 1, 0, 0, 0, 1, 1, 1);
        issue("r_badf7", OP_R, 3'b000, 7'h40, 32'd1, 32'd2, 32'h128, 32'h0, 1, 0, 0, 0, 1, 1, 1);

        b0 = busy_total;
        issue("mulh", OP_R, 3'b001, F7_M, 32'h80000000, 32'h80000000, 0,
              MDIV ? 32'h40000000 : 32'h0, 1, 0, 0, 0, !MDIV, LM, 1);
        wait_drain("mulh");
        chk("mulh busy cycles", busy_total - b0, MDIV ? 32 : 0);
        issue("mul", OP_R, 3'b000, F7_M, 32'd7, 32'hFFFFFFFD, 0, MDIV ? 32'hFFFFFFEB : 0, 1, 0, 0, 0, !MDIV, LM, 1);
        issue("mulhu", OP_R, 3'b011, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, MDIV ? 32'hFFFFFFFE : 0, 1, 0, 0, 0, !MDIV, LM, 1);
        issue("mulhsu", OP_R, 3'b010, F7_M, 32'hFFFFFFFF, 32'd2, 0, MDIV ? 32'hFFFFFFFF : 0, 1, 0, 0, 0, !MDIV, LM, 1);
        issue("div", OP_R, 3'b100, F7_M, 32'hFFFFFFF9, 32'd2, 0, MDIV ? 32'hFFFFFFFD : 0, 1, 0, 0, 0, !MDIV, LM, 1);
        issue("rem", OP_R, 3'b110, F7_M, 32'hFFFFFFF9, 32'd2, 0, MDIV ? 32'hFFFFFFFF : 0, 1, 0, 0, 0, !MDIV, LM, 1);
        issue("divu", OP_R, 3'b101, F7_M, 32'hFFFFFFF9, 32'd2, 0, MDIV ? 32'h7FFFFFFC : 0, 1, 0, 0, 0, !MDIV, LM, 1);
        issue("divu_by0", OP_R, 3'b101, F7_M, 32'd7, 32'd0, 0, MDIV ? 32'hFFFFFFFF : 0, 1, 0, 0, 0, !MDIV, 1, 1);
        issue("rem_by0", OP_R, 3'b110, F7_M, 32'hFFFFFFF9, 32'd0, 0, MDIV ? 32'hFFFFFFF9 : 0, 1, 0, 0, 0, !MDIV, 1, 1);
        issue("div_ovf", OP_R, 3'b100, F7_M, 32'h80000000, 32'hFFFFFFFF, 0, MDIV ? 32'h80000000 : 0, 1, 0, 0, 0, !MDIV, 1, 1);
        issue("rem_ovf", OP_R, 3'b110, F7_M, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 1, 0, 0, 0, !MDIV, 1, 1);
        wait_drain("mdiv");

        out_ready = 1'b0;
        issue("beq_stall", OP_BR, 3'b000, 7'h00, 32'hA, 32'hA, 32'h400, 0, 0, 32'h40A, 1, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall in_ready", in_ready, 1'b0);
            chk("stall out_valid", out_valid, 1'b1);
            chk("stall branch_taken", branch_taken, 1'b1);
            chk("stall jump_target", jump_target, 32'h40A);
            chk("stall pc_plus_4", pc_plus_4, 32'h404);
        end
        out_ready = 1'b1;
        wait_drain("stall");

        issue("mulhu_abort", OP_R, 3'b011, F7_M, 32'h1234, 32'h5678, 32'h500, 32'h0, 1, 0, 0, 0, 1, 1, !MDIV);
        repeat (9) @(posedge clk);
        #2;
        chk("mid-iteration busy", busy, MDIV);
        rst = 1'b1;
        #1;
        chk("abort out_valid", out_valid, 1'b0);
        chk("abort in_ready", in_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue("addi", OP_I, 3'b000, 7'h00, 32'd5, 32'd5, 32'h600, 32'hA, 1, 0, 0, 0, 0, 1, 1);
        wait_drain("final");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
